// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: MMIO bus between the buffered transmit front-end and the UART controller.
//   uart_as_l   address strobe, active low (front-end -> controller)
//   uart_we_l   write enable, active low   (front-end -> controller)
//   uart_sel_h  chip select                (front-end -> controller)
//   uart_addr   register address, 0 = DATA, 1 = STATUS
//   uart_wdata  write data, {24'd0, byte}
//   uart_rdata  registered read data, valid the cycle after a read strobe (controller -> front-end)
interface uart_tx_fifo_if;
  logic        uart_as_l;
  logic        uart_we_l;
  logic        uart_sel_h;
  logic [1:0]  uart_addr;
  logic [31:0] uart_wdata;
  logic [31:0] uart_rdata;

  modport master (
    output uart_as_l,
    output uart_we_l,
    output uart_sel_h,
    output uart_addr,
    output uart_wdata,
    input  uart_rdata
  );

  modport slave (
    input  uart_as_l,
    input  uart_we_l,
    input  uart_sel_h,
    input  uart_addr,
    input  uart_wdata,
    output uart_rdata
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered transmit front-end for the UART controller.
// Bytes pushed by the CPU are queued in a DEPTH-entry circular FIFO. A drain FSM polls the
// controller STATUS register (bit1 = TX busy) and writes the head byte to DATA whenever the
// transmitter reads idle, re-polling before every write.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push_valid/_data    producer offers a byte; taken when push_valid && push_ready
//   push_ready          FIFO not full
//   flush               synchronous discard of all queued bytes, FSM back to idle
//   overflow_clr        synchronous clear of the sticky overflow flag
//   fifo_count          current occupancy
//   overflow            sticky: a push was attempted while full
//   tx_idle             FIFO empty and FSM idle
//   bus                 controller MMIO port (master side)
module uart_tx_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned POLL_GAP = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [7:0]               push_data,
  output logic                     push_ready,
  input  logic                     flush,
  input  logic                     overflow_clr,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     tx_idle,
  uart_tx_fifo_if.master           bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  // Gap counter holds POLL_GAP-1 at most.
  localparam int unsigned GapW = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;
  localparam int unsigned GapLoadInt = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
  localparam logic [GapW-1:0] GapLoad = GapW'(GapLoadInt);

  typedef enum logic [2:0] {StIdle, StRdStat, StChk, StGap, StWrData} state_e;

  state_e            state;
  logic [GapW-1:0]   gap_cnt;
  logic [7:0]        mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic [CntW-1:0]   count;
  logic              do_push;
  logic              do_pop;

  logic              as_l;
  logic              we_l;
  logic              sel_h;
  logic [1:0]        addr;
  logic [31:0]       wdata;

  logic              unused_rdata;
  assign unused_rdata = ^{bus.uart_rdata[31:2], bus.uart_rdata[0]};

  assign push_ready = (count != CntW'(DEPTH));
  assign do_push    = push_valid && push_ready && !flush;
  // The head byte leaves at the end of the write cycle.
  assign do_pop     = (state == StWrData);

  assign fifo_count = count;
  assign tx_idle    = (count == '0) && (state == StIdle);

  assign bus.uart_as_l  = as_l;
  assign bus.uart_we_l  = we_l;
  assign bus.uart_sel_h = sel_h;
  assign bus.uart_addr  = addr;
  assign bus.uart_wdata = wdata;

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // A dropped push wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_valid && !push_ready) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  // Drain FSM. Bus outputs are registered alongside the state so each strobe lines up with the
  // state it belongs to and lasts exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= StIdle;
      gap_cnt <= '0;
      as_l    <= 1'b1;
      we_l    <= 1'b1;
      sel_h   <= 1'b0;
      addr    <= 2'd0;
      wdata   <= 32'd0;
    end else begin
      as_l  <= 1'b1;
      we_l  <= 1'b1;
      sel_h <= 1'b0;
      addr  <= 2'd0;
      wdata <= 32'd0;
      if (flush) begin
        state   <= StIdle;
        gap_cnt <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            if (count != '0) begin
              state <= StRdStat;
              as_l  <= 1'b0;
              sel_h <= 1'b1;
              addr  <= 2'd1;
            end
          end
          StRdStat: begin
            state <= StChk;
          end
          StChk: begin
            if (bus.uart_rdata[1]) begin
              if (POLL_GAP > 0) begin
                state   <= StGap;
                gap_cnt <= GapLoad;
              end else begin
                state <= StRdStat;
                as_l  <= 1'b0;
                sel_h <= 1'b1;
                addr  <= 2'd1;
              end
            end else begin
              state <= StWrData;
              as_l  <= 1'b0;
              we_l  <= 1'b0;
              sel_h <= 1'b1;
              wdata <= {24'd0, mem[rd_ptr]};
            end
          end
          StGap: begin
            if (gap_cnt == '0) begin
              state <= StRdStat;
              as_l  <= 1'b0;
              sel_h <= 1'b1;
              addr  <= 2'd1;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          StWrData: begin
            state <= StIdle;
          end
          default: begin
            state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered transmit front-end that sits directly upstream of the UART controller and masters its MMIO bus port.
- The CPU-side producer pushes bytes into a DEPTH-entry FIFO.
- An internal drain FSM polls the controller STATUS register (addr 1, bit1 = TX busy). Each time the transmitter reads idle, it writes the head byte to DATA (addr 0).
- The CPU can queue a burst of characters without busy-waiting on each byte.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- POLL_GAP, 4, idle cycles inserted between consecutive STATUS polls while TX is busy; 0 means back-to-back polling.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- push_valid  in  1  producer offers push_data this cycle
- push_data  in  8  byte to enqueue
- push_ready  out  1  FIFO not full; push occurs when push_valid && push_ready at posedge
- flush  in  1  synchronous; discard all queued bytes
- overflow_clr  in  1  synchronous; clears overflow
- fifo_count  out  $clog2(DEPTH)+1  occupancy
- overflow  out  1  sticky; a push was attempted while full
- tx_idle  out  1  FIFO empty and FSM in IDLE
- uart_as_l  out  1  address strobe to controller, active low
- uart_we_l  out  1  write enable to controller, active low
- uart_sel_h  out  1  controller chip select
- uart_addr  out  2  0 = DATA, 1 = STATUS
- uart_wdata  out  32  {24'd0, byte}
- uart_rdata  in  32  controller read data; registered by the controller, valid the cycle after a read strobe

Behaviour:
- Reset values:
  - push_ready=1, fifo_count=0, overflow=0, tx_idle=1.
  - uart_as_l=1, uart_we_l=1, uart_sel_h=0, uart_addr=0, uart_wdata=0.
  - Pointers cleared; FSM in IDLE; gap counter 0.
- FIFO storage:
  - Circular buffer with wrapping read/write pointers; fifo_count updates on every push/pop.
  - push_ready = (fifo_count != DEPTH).
  - Push and pop in the same cycle: both take effect and count is unchanged.
  - Push while full is dropped and sets overflow. overflow_clr clears it; if overflow_clr and a dropped push coincide, overflow stays set.
- Bus outputs are Moore, decoded from FSM state.
  - Strobes are asserted for exactly one cycle per transaction.
  - uart_as_l=0 and uart_sel_h=1 only in RD_STAT and WR_DATA.
  - uart_we_l=0 only in WR_DATA.
  - uart_addr=1 in RD_STAT and 0 otherwise.
  - uart_wdata holds {24'd0, head byte} in WR_DATA and 0 otherwise.
- FSM states and transitions:
  - IDLE: if FIFO non-empty -> RD_STAT.
  - RD_STAT: STATUS read strobe -> CHK.
  - CHK: sample uart_rdata[1].
    - If 1 (busy): POLL_GAP>0 -> GAP, loading counter with POLL_GAP-1; POLL_GAP=0 -> RD_STAT.
    - If 0: -> WR_DATA.
  - GAP: counter decrements; at 0 -> RD_STAT.
  - WR_DATA: DATA write strobe; pop head at end of cycle -> IDLE.
- Latency, empty idle FIFO:
  - Push accepted at edge T0.
  - IDLE occupies T0–T1, RD_STAT T1–T2, CHK T2–T3, WR_DATA T3–T4.
  - Pop and fifo_count decrement occur at T4.
- Back-to-back bytes: after WR_DATA the controller reports busy on the next poll. The FSM always re-polls before every write and never issues two writes without an intervening idle STATUS read.
- Flush:
  - At the edge it is sampled, pointers and count go to 0 and the FSM goes to IDLE.
  - A strobe asserted in the flush cycle still completes (controller samples the same edge).
  - A push in the same cycle as flush is discarded.
  - overflow is unaffected.
- Reset mid-transaction: asynchronous return to reset values; strobes deassert immediately.
- fifo_count never exceeds DEPTH; pointer wrap from DEPTH-1 to 0 must be seamless.

Test Plan:
- Reset, then push 0x41 once with a controller model reporting STATUS=0 -> exactly one write strobe with uart_addr=0 and uart_wdata=0x00000041, in the 4th cycle after the accept edge; fifo_count returns to 0; tx_idle=1.
- Push "HELLO" (5 bytes) with the model holding busy for 20 cycles after each write, POLL_GAP=4 -> writes occur in order 0x48,0x45,0x4C,0x4C,0x4F; each preceded by a STATUS read returning bit1=0; polls spaced 6 cycles apart while busy.
- Push 17 bytes into DEPTH=16 with the model always busy -> push_ready=0 after the 16th; the 17th is dropped; overflow=1; fifo_count=16. Pulse overflow_clr -> overflow=0.
- With FIFO half-full, push and drain in the same cycle as WR_DATA -> fifo_count unchanged; byte order preserved across pointer wrap (push 40 bytes total, check the sequence).
- Queue 8 bytes, assert flush during GAP -> fifo_count=0 and FSM in IDLE next cycle; no further write strobes; tx_idle=1.
- Assert reset during WR_DATA -> uart_as_l=1, uart_we_l=1, uart_sel_h=0 without waiting for a clock edge; fifo_count=0 after release.
